// File: rtl/ppu_fb_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ppu_fb_writer: maps PPU pixels (palette optional via FB_PALETTE_EN), packs |
// | four per byte and drains them through a small FIFO to the framebuffer RAM. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ppu_fb_writer #(
  parameter int FB_WIDTH   = 160,
  parameter int FB_HEIGHT  = 144,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        px_in,
  input  logic              px_valid,
  input  logic              frame_sync,
  input  logic [7:0]        bgp,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  input  logic              fb_ready,
  output logic              frame_done,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int XW = $clog2(FB_WIDTH);
  localparam int YW = $clog2(FB_HEIGHT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BYTES_PER_LINE = FB_WIDTH / 4;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WIDTH * FB_HEIGHT / 4 - 1);

  typedef enum logic [0:0] {
    WAIT_SYNC = 1'b0,
    ACTIVE    = 1'b1
  } state_t;

  state_t            state;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [1:0]        pack_cnt;
  logic [5:0]        pack;

  logic [7:0]        fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;

  logic [1:0]        shade;

`ifdef FB_PALETTE_EN
  assign shade = bgp[{px_in, 1'b0} +: 2];
`else
  logic unused_bgp;
  assign unused_bgp = ^bgp;
  assign shade      = px_in;
`endif

  logic              restart;
  logic              px_take;
  logic [XW-1:0]     x_base;
  logic [YW-1:0]     y_base;
  logic [1:0]        cnt_base;
  logic              push;
  logic              pop;
  logic              full;
  logic              push_ok;
  logic              drop;
  logic [ADDR_W-1:0] push_addr;

  // A mid-frame sync rewinds position in the same cycle so a coincident pixel lands at (0,0).
  assign restart   = frame_sync && (state == ACTIVE);
  assign px_take   = px_valid && (state == ACTIVE);
  assign x_base    = restart ? '0 : x;
  assign y_base    = restart ? '0 : y;
  assign cnt_base  = restart ? '0 : pack_cnt;
  assign push      = px_take && (cnt_base == 2'd3);
  assign push_addr = ADDR_W'(y_base) * ADDR_W'(BYTES_PER_LINE) + ADDR_W'(x_base >> 2);

  assign fb_we    = (count != '0);
  assign fb_addr  = fifo_addr[rd_ptr];
  assign fb_wdata = fifo_data[rd_ptr];
  assign pop      = fb_we && fb_ready;
  assign full     = (count == (PW+1)'(FIFO_DEPTH));
  assign push_ok  = push && (!full || pop);
  assign drop     = push && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WAIT_SYNC;
      x        <= '0;
      y        <= '0;
      pack_cnt <= '0;
      pack     <= '0;
    end else begin
      case (state)
        WAIT_SYNC: begin
          if (frame_sync) begin
            state    <= ACTIVE;
            x        <= '0;
            y        <= '0;
            pack_cnt <= '0;
          end
        end
        ACTIVE: begin
          if (px_take) begin
            pack_cnt <= cnt_base + 2'd1;
            case (cnt_base)
              2'd0:    pack[5:4] <= shade;
              2'd1:    pack[3:2] <= shade;
              2'd2:    pack[1:0] <= shade;
              default: ;
            endcase
            if (x_base == XW'(FB_WIDTH - 1)) begin
              x <= '0;
              y <= (y_base == YW'(FB_HEIGHT - 1)) ? '0 : y_base + YW'(1);
            end else begin
              x <= x_base + XW'(1);
              y <= y_base;
            end
          end else if (restart) begin
            x        <= '0;
            y        <= '0;
            pack_cnt <= '0;
          end
        end
        default: state <= WAIT_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        fifo_data[wr_ptr] <= {pack, shade};
        fifo_addr[wr_ptr] <= push_addr;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
      frame_done <= pop && (fb_addr == LAST_ADDR);
      // A drop in the same cycle as a clear must leave the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ppu_fb_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ppu_fb_writer: scoreboard bench for ppu_fb_writer.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ppu_fb_writer;

  localparam int FB_WIDTH   = 160;
  localparam int FB_HEIGHT  = 144;
  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 13;
  localparam int LAST       = FB_WIDTH * FB_HEIGHT / 4 - 1;

`ifdef FB_PALETTE_EN
  localparam logic [7:0] EXP_1B = 8'h1B;
`else
  localparam logic [7:0] EXP_1B = 8'hE4;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        px_in = 2'd0;
  logic              px_valid = 1'b0;
  logic              frame_sync = 1'b0;
  logic [7:0]        bgp = 8'hE4;
  logic              fb_ready = 1'b1;
  logic              ovf_clr = 1'b0;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_wdata;
  logic              frame_done;
  logic              overflow;

  ppu_fb_writer #(
    .FB_WIDTH  (FB_WIDTH),
    .FB_HEIGHT (FB_HEIGHT),
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .px_in     (px_in),
    .px_valid  (px_valid),
    .frame_sync(frame_sync),
    .bgp       (bgp),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_wdata  (fb_wdata),
    .fb_ready  (fb_ready),
    .frame_done(frame_done),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int writes = 0;
  int we_cycles = 0;
  int fd_count = 0;
  bit prev_last = 1'b0;
  logic [ADDR_W+7:0] exp_q[$];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard on every accepted write.
  always @(negedge clk) begin
    if (!rst) begin
      if (fb_we) we_cycles++;
      if (frame_done) fd_count++;
      if (frame_done || prev_last) chk("frame_done_pos", int'(frame_done), int'(prev_last));
      prev_last = 1'b0;
      if (fb_we && fb_ready) begin
        logic [ADDR_W+7:0] e;
        writes++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected none", fb_addr, fb_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", int'(fb_addr), int'(e[ADDR_W+7:8]));
          chk("wr_data", int'(fb_wdata), int'(e[7:0]));
        end
        prev_last = (int'(fb_addr) == LAST);
      end
    end
  end

  task automatic drive(input logic v, input logic [1:0] p, input logic fs);
    @(posedge clk);
    #1;
    px_valid   = v;
    px_in      = p;
    frame_sync = fs;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int j = 3; j >= 0; j--) drive(1'b1, b[2*j +: 2], 1'b0);
  endtask

  task automatic expect_wr(input int a, input logic [7:0] d);
    exp_q.push_back({ADDR_W'(a), d});
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int w0, c0, f0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_fb_we", int'(fb_we), 0);
    chk("rst_fb_addr", int'(fb_addr), 0);
    chk("rst_fb_wdata", int'(fb_wdata), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_overflow", int'(overflow), 0);

    // Pixels before any frame_sync are ignored.
    for (int i = 0; i < 8; i++) drive(1'b1, i[1:0], 1'b0);
    drive(1'b0, 2'd0, 1'b0);
    repeat (6) @(negedge clk);
    chk("presync_writes", writes, 0);

    // Single byte, identity palette.
    w0 = writes; c0 = we_cycles;
    expect_wr(0, 8'hE4);
    drive(1'b0, 2'd0, 1'b1);
    send_byte(8'hE4);
    drive(1'b0, 2'd0, 1'b0);
    wait_drain();
    chk("single_writes", writes - w0, 1);
    chk("single_we_cycles", we_cycles - c0, 1);

    // Reversed palette.
    bgp = 8'h1B;
    w0 = writes;
    expect_wr(0, EXP_1B);
    drive(1'b0, 2'd0, 1'b1);
    send_byte(8'hE4);
    drive(1'b0, 2'd0, 1'b0);
    bgp = 8'hE4;
    wait_drain();
    chk("palette_writes", writes - w0, 1);

    // 162 pixels, then mid-line sync discards the partial byte.
    w0 = writes;
    for (int k = 0; k < 40; k++) expect_wr(k, 8'(k * 3 + 1));
    expect_wr(0, 8'h5A);
    drive(1'b0, 2'd0, 1'b1);
    for (int k = 0; k < 40; k++) send_byte(8'(k * 3 + 1));
    drive(1'b1, 2'd1, 1'b0);
    drive(1'b1, 2'd1, 1'b0);
    drive(1'b0, 2'd0, 1'b1);
    send_byte(8'h5A);
    drive(1'b0, 2'd0, 1'b0);
    wait_drain();
    chk("midline_writes", writes - w0, 41);

    // Full frame.
    w0 = writes; f0 = fd_count;
    for (int k = 0; k <= LAST; k++) expect_wr(k, k[7:0]);
    drive(1'b0, 2'd0, 1'b1);
    for (int k = 0; k <= LAST; k++) send_byte(k[7:0]);
    drive(1'b0, 2'd0, 1'b0);
    wait_drain();
    chk("frame_writes", writes - w0, LAST + 1);
    chk("frame_done_count", fd_count - f0, 1);
    chk("frame_overflow", int'(overflow), 0);

    // 40-pixel stall with RAM not ready.
    w0 = writes;
    for (int k = 0; k < 4; k++) expect_wr(k, 8'(8'h10 + k));
    drive(1'b0, 2'd0, 1'b1);
    fb_ready = 1'b0;
    for (int k = 0; k < 10; k++) send_byte(8'(8'h10 + k));
    drive(1'b0, 2'd0, 1'b0);
    @(negedge clk);
    chk("stall_overflow", int'(overflow), 1);
    chk("stall_writes", writes - w0, 0);
    expect_wr(10, 8'hA5);
    drive(1'b0, 2'd0, 1'b0);
    fb_ready = 1'b1;
    send_byte(8'hA5);
    drive(1'b0, 2'd0, 1'b0);
    wait_drain();
    chk("stall_total_writes", writes - w0, 5);

    // ovf_clr held across a new drop: the set wins.
    w0 = writes;
    drive(1'b0, 2'd0, 1'b1);
    fb_ready = 1'b0;
    ovf_clr  = 1'b1;
    for (int k = 0; k < 4; k++) send_byte(8'(8'hC0 + k));
    @(negedge clk);
    chk("clr_before_drop", int'(overflow), 0);
    send_byte(8'hC4);
    drive(1'b0, 2'd0, 1'b0);
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("set_wins_over_clr", int'(overflow), 1);
    for (int k = 0; k < 4; k++) expect_wr(k, 8'(8'hC0 + k));
    drive(1'b0, 2'd0, 1'b0);
    fb_ready = 1'b1;
    wait_drain();
    chk("clr_test_writes", writes - w0, 4);
    chk("overflow_sticky", int'(overflow), 1);
    drive(1'b0, 2'd0, 1'b0);
    ovf_clr = 1'b1;
    drive(1'b0, 2'd0, 1'b0);
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_clr_alone", int'(overflow), 0);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
